// File: rtl/ma_stage_if.sv
// Shared pipeline bundle types for the memory-access stage, and the data-memory
// req/ack bus it masters.
package ma_stage_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              isLd;
    logic              isSt;
    logic              regWrite;
    logic              memToReg;
    logic [REG_AW-1:0] rd;
  } Ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] instr;
    Ctrl_t           ctrl;
  } Ex_Ma_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] ldresult;
    logic [XLEN-1:0] instr;
    Ctrl_t           ctrl;
  } Ma_Rw_t;
endpackage

interface ma_stage_if;
  import ma_stage_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: single outstanding load/store with bounded wait.
// Optional MA_ALIGN_CHECK_EN faults misaligned accesses without touching memory.
module ma_stage
  import ma_stage_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  Ex_Ma_t            ex_ma_q,
  input  logic              ex_ma_valid,
  output logic              ma_stall,
  ma_stage_if.master        dmem,
  output Ma_Rw_t            ma_rw_q,
  output logic              ma_rw_valid,
  output logic              mem_err
);

  localparam int unsigned    CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  Ex_Ma_t           hold;
  logic             is_mem;
  logic             misaligned;

  function automatic Ma_Rw_t to_rw(input Ex_Ma_t b, input logic [XLEN-1:0] ld);
    Ma_Rw_t r;
    r.pc        = b.pc;
    r.aluresult = b.aluresult;
    r.ldresult  = ld;
    r.instr     = b.instr;
    r.ctrl      = b.ctrl;
    return r;
  endfunction

  assign is_mem = ex_ma_q.ctrl.isLd | ex_ma_q.ctrl.isSt;

`ifdef MA_ALIGN_CHECK_EN
  assign misaligned = |ex_ma_q.aluresult[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign ma_stall = (state == BUSY);

  // Stage FSM; retire pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hold        <= '0;
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= '0;
      dmem.wdata  <= '0;
      ma_rw_q     <= '0;
      ma_rw_valid <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      ma_rw_valid <= 1'b0;
      mem_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_ma_valid) begin
            if (!is_mem) begin
              ma_rw_q     <= to_rw(ex_ma_q, '0);
              ma_rw_valid <= 1'b1;
            end else if (misaligned) begin
              ma_rw_q     <= to_rw(ex_ma_q, '0);
              ma_rw_valid <= 1'b1;
              mem_err     <= 1'b1;
            end else begin
              // Both isLd and isSt set resolves to a store via we.
              hold       <= ex_ma_q;
              dmem.req   <= 1'b1;
              dmem.we    <= ex_ma_q.ctrl.isSt;
              dmem.addr  <= ex_ma_q.aluresult;
              dmem.wdata <= ex_ma_q.op2;
              cnt        <= '0;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem.ack) begin
            dmem.req    <= 1'b0;
            ma_rw_q     <= to_rw(hold, hold.ctrl.isSt ? '0 : dmem.rdata);
            ma_rw_valid <= 1'b1;
            state       <= IDLE;
          end else if (cnt == CNT_LAST) begin
            dmem.req    <= 1'b0;
            ma_rw_q     <= to_rw(hold, '0);
            ma_rw_valid <= 1'b1;
            mem_err     <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: directed scenarios plus randomized traffic
// against a word-array memory reference model.
module tb_ma_stage;
  import ma_stage_pkg::*;

  localparam int unsigned TO = 4;

  logic   clk = 1'b0;
  logic   rst;
  Ex_Ma_t ex;
  logic   ex_valid;
  logic   stall;
  Ma_Rw_t rw;
  logic   rw_valid;
  logic   err;

  ma_stage_if dmem_bus ();

  ma_stage #(.MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_ma_q    (ex),
    .ex_ma_valid(ex_valid),
    .ma_stall   (stall),
    .dmem       (dmem_bus),
    .ma_rw_q    (rw),
    .ma_rw_valid(rw_valid),
    .mem_err    (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_ref [64];
  logic [31:0] mem_dev [64];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 load+store (acts as store)
  function automatic Ex_Ma_t mkop(input int kind, input logic [31:0] a, input logic [31:0] d);
    Ex_Ma_t o;
    o.pc            = $urandom;
    o.aluresult     = a;
    o.op2           = d;
    o.instr         = $urandom;
    o.ctrl.isLd     = (kind == 1) || (kind == 3);
    o.ctrl.isSt     = (kind == 2) || (kind == 3);
    o.ctrl.regWrite = (kind == 0) || (kind == 1);
    o.ctrl.memToReg = (kind == 1);
    o.ctrl.rd       = 5'($urandom);
    return o;
  endfunction

  function automatic Ma_Rw_t exp_rw(input Ex_Ma_t o, input logic [31:0] ld);
    Ma_Rw_t r;
    r.pc        = o.pc;
    r.aluresult = o.aluresult;
    r.ldresult  = ld;
    r.instr     = o.instr;
    r.ctrl      = o.ctrl;
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1; ex = '0; ex_valid = 1'b0;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
    repeat (3) step;
    total++;
    if ({stall, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, rw_valid, err} !== '0 || rw !== '0) begin
      bad++;
      $display("FAIL reset_state got stall=%b req=%b we=%b addr=%h wdata=%h rw=%h v=%b err=%b exp all zero",
               stall, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, rw, rw_valid, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu;
    Ex_Ma_t op;
    op = mkop(0, 32'h0000_0005, 32'h0);
    ex = op; ex_valid = 1'b1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall_t got=%b exp=0", stall); end
    step;
    ex_valid = 1'b0;
    total++;
    if (rw_valid !== 1'b1 || rw !== exp_rw(op, 32'h0) || err !== 1'b0) begin
      bad++; $display("FAIL alu_retire got v=%b err=%b rw=%h exp v=1 err=0 rw=%h", rw_valid, err, rw, exp_rw(op, 32'h0));
    end
    total++;
    if (dmem_bus.req !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL alu_no_req got req=%b stall=%b exp 0 0", dmem_bus.req, stall);
    end
  endtask

  task automatic test_load;
    Ex_Ma_t op;
    op = mkop(1, 32'h0000_0100, 32'h0);
    ex = op; ex_valid = 1'b1;
    step;
    ex_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      total++;
      if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, stall, rw_valid} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b0}) begin
        bad++; $display("FAIL load_wait[%0d] got req=%b we=%b addr=%h stall=%b v=%b exp 1 0 00000100 1 0",
                        j, dmem_bus.req, dmem_bus.we, dmem_bus.addr, stall, rw_valid);
      end
      if (j == 3) begin dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hCAFE_F00D; end
      step;
    end
    dmem_bus.ack = 1'b0;
    total++;
    if (rw_valid !== 1'b1 || rw !== exp_rw(op, 32'hCAFE_F00D) || err !== 1'b0 || stall !== 1'b0 || dmem_bus.req !== 1'b0) begin
      bad++; $display("FAIL load_retire got v=%b err=%b stall=%b req=%b rw=%h exp rw=%h",
                      rw_valid, err, stall, dmem_bus.req, rw, exp_rw(op, 32'hCAFE_F00D));
    end
  endtask

  task automatic test_back_to_back;
    Ex_Ma_t st, alu;
    st  = mkop(2, 32'h0000_0200, 32'h1234_5678);
    alu = mkop(0, 32'hA5A5_0001, 32'h0);
    ex = st; ex_valid = 1'b1;
    step;
    total++;
    if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, stall} !== {1'b1, 1'b1, 32'h200, 32'h1234_5678, 1'b1}) begin
      bad++; $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h stall=%b exp 1 1 00000200 12345678 1",
                      dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, stall);
    end
    ex = alu; dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'hDEAD_BEEF;
    step;
    dmem_bus.ack = 1'b0;
    total++;
    if (rw_valid !== 1'b1 || rw !== exp_rw(st, 32'h0) || stall !== 1'b0) begin
      bad++; $display("FAIL store_retire got v=%b stall=%b rw=%h exp v=1 stall=0 rw=%h", rw_valid, stall, rw, exp_rw(st, 32'h0));
    end
    step;
    ex_valid = 1'b0;
    total++;
    if (rw_valid !== 1'b1 || rw !== exp_rw(alu, 32'h0)) begin
      bad++; $display("FAIL held_alu_retire got v=%b rw=%h exp v=1 rw=%h", rw_valid, rw, exp_rw(alu, 32'h0));
    end
    step;
    total++;
    if (rw_valid !== 1'b0 || rw !== exp_rw(alu, 32'h0)) begin
      bad++; $display("FAIL rw_hold got v=%b rw=%h exp v=0 rw=%h", rw_valid, rw, exp_rw(alu, 32'h0));
    end
  endtask

  task automatic test_timeout;
    Ex_Ma_t op;
    op = mkop(1, 32'h0000_0040, 32'h0);
    ex = op; ex_valid = 1'b1;
    step;
    ex_valid = 1'b0;
    for (int j = 1; j <= int'(TO); j++) begin
      total++;
      if ({dmem_bus.req, stall, rw_valid} !== 3'b110) begin
        bad++; $display("FAIL timeout_wait[%0d] got req=%b stall=%b v=%b exp 1 1 0", j, dmem_bus.req, stall, rw_valid);
      end
      step;
    end
    total++;
    if (rw_valid !== 1'b1 || err !== 1'b1 || rw !== exp_rw(op, 32'h0) || stall !== 1'b0 || dmem_bus.req !== 1'b0) begin
      bad++; $display("FAIL timeout_retire got v=%b err=%b stall=%b req=%b rw=%h exp v=1 err=1 rw=%h",
                      rw_valid, err, stall, dmem_bus.req, rw, exp_rw(op, 32'h0));
    end
    step;
    total++;
    if (err !== 1'b0 || rw_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse got v=%b err=%b exp 0 0", rw_valid, err);
    end
  endtask

  task automatic test_reset_mid;
    ex = mkop(1, 32'h0000_0080, 32'h0); ex_valid = 1'b1;
    step;
    ex_valid = 1'b0;
    total++;
    if (dmem_bus.req !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%b exp=1", dmem_bus.req); end
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    total++;
    if ({stall, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, rw_valid, err} !== '0 || rw !== '0) begin
      bad++; $display("FAIL rstmid_zero got stall=%b req=%b we=%b addr=%h wdata=%h rw=%h v=%b err=%b exp all zero",
                      stall, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, rw, rw_valid, err);
    end
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h5555_AAAA;
    step;
    dmem_bus.ack = 1'b0;
    total++;
    if ({rw_valid, dmem_bus.req, stall, err} !== 4'b0000 || rw !== '0) begin
      bad++; $display("FAIL late_ack got v=%b req=%b stall=%b err=%b rw=%h exp all zero", rw_valid, dmem_bus.req, stall, err, rw);
    end
  endtask

  task automatic test_align;
    Ex_Ma_t op;
    op = mkop(1, 32'h0000_0102, 32'h0);
    ex = op; ex_valid = 1'b1;
    step;
    ex_valid = 1'b0;
`ifdef MA_ALIGN_CHECK_EN
    total++;
    if (dmem_bus.req !== 1'b0 || stall !== 1'b0 || rw_valid !== 1'b1 || err !== 1'b1 || rw !== exp_rw(op, 32'h0)) begin
      bad++; $display("FAIL misalign_fault got req=%b stall=%b v=%b err=%b rw=%h exp 0 0 1 1 rw=%h",
                      dmem_bus.req, stall, rw_valid, err, rw, exp_rw(op, 32'h0));
    end
`else
    total++;
    if (dmem_bus.req !== 1'b1 || dmem_bus.addr !== 32'h0000_0102) begin
      bad++; $display("FAIL misalign_req got req=%b addr=%h exp 1 00000102", dmem_bus.req, dmem_bus.addr);
    end
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h0BAD_F00D;
    step;
    dmem_bus.ack = 1'b0;
    total++;
    if (rw_valid !== 1'b1 || err !== 1'b0 || rw !== exp_rw(op, 32'h0BAD_F00D)) begin
      bad++; $display("FAIL misalign_retire got v=%b err=%b rw=%h exp v=1 err=0 rw=%h", rw_valid, err, rw, exp_rw(op, 32'h0BAD_F00D));
    end
`endif
  endtask

  task automatic test_random;
    Ex_Ma_t      op;
    Ma_Rw_t      exp;
    logic [31:0] a, ld;
    logic [5:0]  idx;
    logic        is_mem, mis, acked, exp_err;
    int          kind, delay, gap;
    for (int i = 0; i < 64; i++) begin
      mem_ref[i] = $urandom;
      mem_dev[i] = mem_ref[i];
    end
    for (int n = 0; n < 80; n++) begin
      kind  = int'($urandom_range(0, 3));
      idx   = 6'($urandom);
      a     = {24'h0, idx, 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      delay = int'($urandom_range(1, TO + 1));
      gap   = int'($urandom_range(0, 1));
      op    = mkop(kind, a, $urandom);
      is_mem = op.ctrl.isLd || op.ctrl.isSt;
`ifdef MA_ALIGN_CHECK_EN
      mis = is_mem && (a[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      ex = op; ex_valid = 1'b1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL rnd_idle_stall[%0d] got=%b exp=0", n, stall); end
      step;
      ex_valid = 1'b0;
      ex = mkop(int'($urandom_range(0, 3)), $urandom, $urandom);
      if (!is_mem || mis) begin
        exp = exp_rw(op, 32'h0);
        exp_err = mis;
      end else begin
        acked = 1'b0;
        for (int j = 1; j <= int'(TO) && !acked; j++) begin
          total++;
          if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, stall, rw_valid} !==
              {1'b1, op.ctrl.isSt, a, op.op2, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rnd_req[%0d.%0d] got req=%b we=%b addr=%h wdata=%h stall=%b v=%b exp 1 %b %h %h 1 0",
                            n, j, dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata, stall, rw_valid,
                            op.ctrl.isSt, a, op.op2);
          end
          if (j == delay) begin
            dmem_bus.ack = 1'b1;
            if (dmem_bus.we) begin
              mem_dev[dmem_bus.addr[7:2]] = dmem_bus.wdata;
              dmem_bus.rdata = $urandom;
            end else begin
              dmem_bus.rdata = mem_dev[dmem_bus.addr[7:2]];
            end
            acked = 1'b1;
          end
          step;
          dmem_bus.ack = 1'b0;
        end
        if (delay <= int'(TO)) begin
          ld = op.ctrl.isSt ? 32'h0 : mem_ref[idx];
          if (op.ctrl.isSt) mem_ref[idx] = op.op2;
          exp_err = 1'b0;
        end else begin
          ld = 32'h0;
          exp_err = 1'b1;
        end
        exp = exp_rw(op, ld);
      end
      total++;
      if (rw_valid !== 1'b1 || rw !== exp || err !== exp_err || stall !== 1'b0 || dmem_bus.req !== 1'b0) begin
        bad++; $display("FAIL rnd_retire[%0d] got v=%b err=%b stall=%b req=%b rw=%h exp v=1 err=%b rw=%h",
                        n, rw_valid, err, stall, dmem_bus.req, rw, exp_err, exp);
      end
      for (int g = 0; g < gap; g++) begin
        step;
        total++;
        if (rw_valid !== 1'b0 || err !== 1'b0 || rw !== exp) begin
          bad++; $display("FAIL rnd_hold[%0d] got v=%b err=%b rw=%h exp v=0 err=0 rw=%h", n, rw_valid, err, rw, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_align;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the 32-bit in-order pipeline. Sits directly downstream of the execute stage: it consumes the registered `Ex_Ma_t` bundle and its valid bit. It performs loads and stores against a single-ported data memory using a req/ack handshake with a bounded wait. It registers the `Ma_Rw_t` bundle for the register-write stage. While a memory access is outstanding, it back-pressures execute through `ma_stall`.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: cycles in BUSY without `dmem_ack` before the access is abandoned; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ex_ma_q` in `Ex_Ma_t`: EX→MA bundle; uses `pc`, `aluresult` (address/result), `op2` (store data), `instr`, `ctrl` (`isLd`, `isSt`, plus write-back controls).
- `ex_ma_valid` in 1: `ex_ma_q` holds a real instruction.
- `ma_stall` out 1: execute must hold `ex_ma_q`/`ex_ma_valid` this cycle.
- `dmem_req` out 1: access request, registered.
- `dmem_we` out 1: 1 = store, 0 = load; valid while `dmem_req`.
- `dmem_addr` out 32: byte address, registered.
- `dmem_wdata` out 32: store data, registered.
- `dmem_rdata` in 32: load data; sampled only in the ack cycle.
- `dmem_ack` in 1: access complete; single-cycle pulse.
- `ma_rw_q` out `Ma_Rw_t`: registered MA→RW bundle: `pc`, `aluresult`, `ldresult`, `instr`, `ctrl`.
- `ma_rw_valid` out 1: `ma_rw_q` is a real instruction; a one-cycle qualifier per instruction.
- `mem_err` out 1: one-cycle pulse, coincident with `ma_rw_valid`, for a faulted access.

## Operation
- FSM states:
  - IDLE (reset state): accepts input.
  - BUSY: holds the captured memory instruction, with a request outstanding.
- IDLE, `ex_ma_valid`=0: `ma_rw_valid`←0.
- IDLE, valid, neither `isLd` nor `isSt`:
  - next cycle `ma_rw_q`←bundle with `ldresult`=0, `ma_rw_valid`←1.
  - stay IDLE.
- IDLE, valid, `isLd` or `isSt`:
  - capture the bundle into the hold register.
  - `dmem_req`←1, `dmem_we`←`isSt`, `dmem_addr`←`aluresult`, `dmem_wdata`←`op2`.
  - clear the timeout counter; →BUSY.
  - `ma_rw_valid`←0.
- If both `isLd` and `isSt` are set, the instruction is treated as a store.
- BUSY:
  - `dmem_req` stays high; address, data and `we` are held stable.
  - the counter increments each cycle without ack.
- BUSY with `dmem_ack`=1:
  - `dmem_req`←0.
  - `ma_rw_q`←hold register, with `ldresult`←`dmem_rdata` for a load, 0 for a store.
  - `ma_rw_valid`←1; →IDLE.
- BUSY, no ack, counter = `MEM_TIMEOUT`-1:
  - `dmem_req`←0.
  - retire with `ldresult`=0; `ma_rw_valid`←1, `mem_err`←1; →IDLE.
  - an ack in this same cycle takes priority: normal completion, no error.
- `ma_stall` = (state==BUSY), combinational. It is asserted in the ack cycle too, so the next instruction is accepted the cycle after completion.
- `dmem_ack` in IDLE is ignored.
- `ma_rw_q` holds its last value when `ma_rw_valid`=0.
- There is no flush input: instructions in MA are older than any resolved branch and always retire.
- `rst` at any time, including mid-BUSY, sets:
  - state=IDLE, counter=0.
  - `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - `ma_rw_q`='0, `ma_rw_valid`=0, `mem_err`=0.
  - `ma_stall` therefore 0.
  - A late ack after reset is ignored.

## Timing
- Non-memory instruction accepted at cycle T: `ma_rw_valid` at T+1; throughput 1/cycle.
- Memory instruction accepted at T:
  - `dmem_req` high from T+1.
  - ack at T+k (k≥1) gives `ma_rw_valid` at T+k+1.
  - `ma_stall` high T+1..T+k; next accept at T+k+1.
- Timeout: req high T+1..T+`MEM_TIMEOUT`; error retire at T+`MEM_TIMEOUT`+1.
- Back-to-back memory ops with zero-wait memory (ack at T+1): one op per 2 cycles.

## Configuration
- `MA_ALIGN_CHECK_EN` defined:
  - a load/store with `aluresult[1:0]`≠0 in IDLE issues no request and stays IDLE.
  - it retires next cycle with `ldresult`=0, `ma_rw_valid`=1, `mem_err`=1.
  - a misaligned store writes nothing.
- Undefined: no check; every address is driven to `dmem_addr` unchanged, and `mem_err` is asserted only on timeout.

## Test plan
- Reset, then ALU op `aluresult`=0x0000_0005 valid at T → `ma_rw_valid`=1 at T+1 with `aluresult`=0x5, `ldresult`=0, no `dmem_req`, `ma_stall`=0 throughout.
- Load at address 0x100 at T, memory acks at T+3 with `rdata`=0xCAFE_F00D:
  - `dmem_req`/`we`=1/0 with `addr`=0x100 during T+1..T+3.
  - `ma_stall`=1 during T+1..T+3.
  - `ma_rw_valid`=1 with `ldresult`=0xCAFE_F00D at T+4.
- Store at 0x200 with `op2`=0x1234_5678, held ALU op behind it, ack at T+1:
  - `we`=1, `wdata`=0x1234_5678.
  - store retires T+2; ALU op accepted T+2, retires T+3.
- `MEM_TIMEOUT`=4, load, never ack → req high T+1..T+4; retire at T+5 with `mem_err`=1, `ldresult`=0; IDLE at T+5.
- `rst` asserted at T+2 of a pending load, then ack at T+3 → all outputs zero from T+3; ack ignored, no `ma_rw_valid`.
- With `MA_ALIGN_CHECK_EN`: load at 0x102 → no `dmem_req`; `ma_rw_valid`=`mem_err`=1 at T+1. Without the macro, `dmem_addr`=0x102 is requested.
